// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: latches hall/cabin calls, sweeps one direction while calls lie ahead, then reverses.
// Optional ELEVATOR_DOOR_HOLD_EN: door_hold keeps reloading the door dwell counter.
module elevator_scan_ctrl #(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = $clog2(FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  f_req,
  input  logic [FLOORS-1:0]  c_req,
  input  logic               door_hold,
  output logic [FLOORS-1:0]  request,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               direction,
  output logic               moving,
  output logic               door_open,
  output logic               arrived
);

  localparam int TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAV_W-1:0] TRAV_LOAD = TRAV_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [FLOORS-1:0]   request_n;
  logic [FLOOR_W-1:0]  floor_n;
  logic [FLOOR_W-1:0]  next_floor;
  logic                direction_n;
  logic                arrived_n;
  logic [TRAV_W-1:0]   travel_cnt, travel_cnt_n;
  logic [DOOR_W-1:0]   door_cnt, door_cnt_n;
  logic [FLOORS-1:0]   calls;
  logic                here;
  logic                above;
  logic                below;
  logic                ahead;
  logic                behind;
  logic                hold_eff;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold_eff = door_hold;
`else
  assign hold_eff = door_hold & 1'b0;
`endif

  assign calls     = f_req | c_req;
  assign here      = calls[current_floor];
  assign ahead     = direction ? above : below;
  assign behind    = direction ? below : above;
  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int k = 0; k < FLOORS; k++) begin
      if (k > int'(current_floor)) above = above | request[k];
      if (k < int'(current_floor)) below = below | request[k];
    end
  end

  always_comb begin
    state_n      = state;
    request_n    = request | calls;
    floor_n      = current_floor;
    direction_n  = direction;
    arrived_n    = 1'b0;
    travel_cnt_n = travel_cnt;
    door_cnt_n   = door_cnt;
    next_floor   = direction ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);

    case (state)
      IDLE: begin
        // Calls for the floor we are parked at open the door instead of being stored.
        request_n[current_floor] = 1'b0;
        if (here) begin
          state_n    = DOOR;
          door_cnt_n = DOOR_LOAD;
        end else if (ahead) begin
          state_n      = MOVE;
          travel_cnt_n = TRAV_LOAD;
        end else if (behind) begin
          state_n      = MOVE;
          direction_n  = ~direction;
          travel_cnt_n = TRAV_LOAD;
        end
      end

      MOVE: begin
        if (travel_cnt == '0) begin
          floor_n   = next_floor;
          arrived_n = 1'b1;
          if (request[next_floor] || calls[next_floor]) begin
            request_n[next_floor] = 1'b0;
            state_n               = DOOR;
            door_cnt_n            = DOOR_LOAD;
          end else begin
            travel_cnt_n = TRAV_LOAD;
          end
        end else begin
          travel_cnt_n = travel_cnt - TRAV_W'(1);
        end
      end

      DOOR: begin
        request_n[current_floor] = 1'b0;
        if (here || hold_eff) begin
          door_cnt_n = DOOR_LOAD;
        end else if (door_cnt == '0) begin
          if (ahead) begin
            state_n      = MOVE;
            travel_cnt_n = TRAV_LOAD;
          end else if (behind) begin
            state_n      = MOVE;
            direction_n  = ~direction;
            travel_cnt_n = TRAV_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          door_cnt_n = door_cnt - DOOR_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      request       <= '0;
      current_floor <= '0;
      direction     <= 1'b1;
      arrived       <= 1'b0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
    end else begin
      state         <= state_n;
      request       <= request_n;
      current_floor <= floor_n;
      direction     <= direction_n;
      arrived       <= arrived_n;
      travel_cnt    <= travel_cnt_n;
      door_cnt      <= door_cnt_n;
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3).
module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] f_req = '0;
  logic [7:0] c_req = '0;
  logic       door_hold = 1'b0;
  logic [7:0] request;
  logic [2:0] current_floor;
  logic       direction;
  logic       moving;
  logic       door_open;
  logic       arrived;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  int stop_n;
  int stop_floor [8];
  int stop_dir   [8];
  int stop_edge  [8];
  int arr_cnt;
  int dir_bad;
  logic prev_door;

  elevator_scan_ctrl #(
    .FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .f_req(f_req), .c_req(c_req), .door_hold(door_hold),
    .request(request), .current_floor(current_floor), .direction(direction),
    .moving(moving), .door_open(door_open), .arrived(arrived)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic clear_rec();
    stop_n = 0; arr_cnt = 0; dir_bad = 0; prev_door = door_open;
  endtask

  task automatic run(input int n, input logic want_dir, input logic check_dir);
    for (int i = 0; i < n; i++) begin
      tick();
      if (arrived) arr_cnt++;
      if (check_dir && direction !== want_dir) dir_bad++;
      if (door_open && !prev_door && stop_n < 8) begin
        stop_floor[stop_n] = int'(current_floor);
        stop_dir[stop_n]   = int'(direction);
        stop_edge[stop_n]  = cyc;
        stop_n++;
      end
      prev_door = door_open;
    end
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_request", request, 0);
    chk("rst_floor", current_floor, 0);
    chk("rst_dir", direction, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_arrived", arrived, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;

    // Single hall pulse for floor 5
    f_req = 8'h20;
    tick();
    f_req = '0;
    chk("t1_req_e1", request, 8'h20);
    chk("t1_moving_e1", moving, 0);
    tick();
    chk("t1_moving_e2", moving, 1);
    for (int f = 1; f <= 5; f++) begin
      repeat (3) tick();
      chk("t1_floor_pre", current_floor, f - 1);
      chk("t1_arr_pre", arrived, 0);
      tick();
      chk("t1_floor_arr", current_floor, f);
      chk("t1_arr_pulse", arrived, 1);
    end
    chk("t1_edge22", cyc, 22);
    chk("t1_door_e22", door_open, 1);
    chk("t1_req_e22", request, 0);
    chk("t1_moving_e22", moving, 0);
    tick();
    chk("t1_door_e23", door_open, 1);
    chk("t1_arr_e23", arrived, 0);
    tick();
    chk("t1_door_e24", door_open, 1);
    tick();
    chk("t1_door_e25", door_open, 0);
    chk("t1_moving_e25", moving, 0);

    // Two cabin calls from floor 0
    do_reset();
    clear_rec();
    c_req = 8'h44;
    run(1, 1'b1, 1'b1);
    c_req = '0;
    chk("t2_req_e1", request, 8'h44);
    run(39, 1'b1, 1'b1);
    chk("t2_nstops", stop_n, 2);
    chk("t2_stop0", stop_floor[0], 2);
    chk("t2_edge0", stop_edge[0], 10);
    chk("t2_stop1", stop_floor[1], 6);
    chk("t2_edge1", stop_edge[1], 29);
    chk("t2_arrivals", arr_cnt, 6);
    chk("t2_dir_bad", dir_bad, 0);
    chk("t2_end_door", door_open, 0);
    chk("t2_end_moving", moving, 0);

    // Calls above and below while sweeping up toward 6
    do_reset();
    c_req = 8'h40;
    tick();
    c_req = '0;
    repeat (13) tick();
    chk("t3_floor_e14", current_floor, 3);
    chk("t3_moving_e14", moving, 1);
    tick();
    clear_rec();
    f_req = 8'h82;
    run(1, 1'b1, 1'b0);
    f_req = '0;
    run(59, 1'b1, 1'b0);
    chk("t3_nstops", stop_n, 3);
    chk("t3_stop0", stop_floor[0], 6);
    chk("t3_dir0", stop_dir[0], 1);
    chk("t3_edge0", stop_edge[0], 26);
    chk("t3_stop1", stop_floor[1], 7);
    chk("t3_dir1", stop_dir[1], 1);
    chk("t3_edge1", stop_edge[1], 33);
    chk("t3_stop2", stop_floor[2], 1);
    chk("t3_dir2", stop_dir[2], 0);
    chk("t3_edge2", stop_edge[2], 60);
    chk("t3_arrivals", arr_cnt, 10);
    chk("t3_req_end", request, 0);

    // Current-floor call while idle and during DOOR
    do_reset();
    c_req = 8'h10;
    tick();
    c_req = '0;
    repeat (21) tick();
    chk("t4_floor", current_floor, 4);
    chk("t4_idle_door", door_open, 0);
    f_req = 8'h10;
    tick();
    f_req = '0;
    chk("t4_door_e23", door_open, 1);
    chk("t4_req_e23", request, 0);
    tick();
    chk("t4_door_e24", door_open, 1);
    f_req = 8'h10;
    tick();
    f_req = '0;
    chk("t4_req_e25", request, 0);
    tick();
    chk("t4_door_e26", door_open, 1);
    tick();
    chk("t4_door_e27", door_open, 1);
    tick();
    chk("t4_door_e28", door_open, 0);
    chk("t4_req_e28", request, 0);

    // door_hold for 10 cycles
    f_req = 8'h10;
    tick();
    f_req = '0;
    chk("t5_door_open", door_open, 1);
    for (int i = 1; i <= 13; i++) begin
      door_hold = (i <= 10);
      tick();
`ifdef ELEVATOR_DOOR_HOLD_EN
      chk("t5_door_hold", door_open, (i <= 12) ? 1 : 0);
`else
      chk("t5_door_fixed", door_open, (i <= 2) ? 1 : 0);
`endif
    end
    door_hold = 1'b0;

    // Asynchronous reset in the middle of travel
    do_reset();
    c_req = 8'h40;
    tick();
    c_req = '0;
    repeat (14) tick();
    chk("t6_floor_pre", current_floor, 3);
    chk("t6_req_pre", request, 8'h40);
    #2 rst = 1'b1;
    #1;
    chk("t6_floor_rst", current_floor, 0);
    chk("t6_req_rst", request, 0);
    chk("t6_moving_rst", moving, 0);
    chk("t6_dir_rst", direction, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) tick();
    chk("t6_moving_after", moving, 0);
    chk("t6_door_after", door_open, 0);
    chk("t6_floor_after", current_floor, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
